// File: rtl/td4_prog_loader_if.sv
// Byte-stream load port and instruction-fetch read port of the TD4 program store.
interface td4_prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output addr,
        input  data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  addr,
        output data
    );
endinterface

// File: rtl/td4_prog_loader.sv
// TD4 program loader: 16x8 writable instruction store filled from a byte stream; holds the core in reset while loading.
// Optional trailing checksum byte with HALT on mismatch is built when LOADER_CHECKSUM_EN is defined.
module td4_prog_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    td4_prog_loader_if.slave  bus,
    output logic              core_reset_n,
    output logic              loading,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Program plus checksum byte must sum to zero modulo 256.
    function automatic logic checksum_ok(input logic [DATA_W-1:0] sum_v,
                                         input logic [DATA_W-1:0] byte_v);
        logic [DATA_W-1:0] total_v;
        total_v = sum_v + byte_v;
        return (total_v == {DATA_W{1'b0}});
    endfunction
`else
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              wr_en_s;
    logic              accept_s;
    logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              error_q, error_d;
`endif

    assign accept_s = bus.in_valid & in_ready_q;

    // Next-state, write-enable and registered-output decode.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        done_d   = 1'b0;
        wr_en_s  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        error_d  = error_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (load_req) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = {ADDR_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = {DATA_W{1'b0}};
                    error_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum_q + bus.in_data;
`endif
                    if (wr_ptr_q == PTR_LAST) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_RUN;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    if (checksum_ok(sum_q, bus.in_data)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_HALT: begin
                if (load_req) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = {ADDR_W{1'b0}};
                    sum_d    = {DATA_W{1'b0}};
                    error_d  = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Core and stream-ready follow where the FSM is going, so they change on the same edge.
        core_reset_n_d = (state_d == ST_RUN);
`ifdef LOADER_CHECKSUM_EN
        in_ready_d     = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
        in_ready_d     = (state_d == ST_LOAD);
`endif
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            wr_ptr_q       <= {ADDR_W{1'b0}};
            core_reset_n_q <= 1'b0;
            in_ready_q     <= 1'b0;
            done_q         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= {DATA_W{1'b0}};
            error_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            core_reset_n_q <= core_reset_n_d;
            in_ready_q     <= in_ready_d;
            done_q         <= done_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
            error_q        <= error_d;
`endif
        end
    end

    // Program store; reset clears it so an aborted load never leaves a partial program.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign bus.data     = mem_q[bus.addr];
    assign bus.in_ready = in_ready_q;
    assign core_reset_n = core_reset_n_q;
    assign wr_ptr       = wr_ptr_q;
    assign done         = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign loading      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign error        = error_q;
`else
    assign loading      = (state_q == ST_LOAD);
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed self-checking bench for td4_prog_loader; checksum scenario built only with LOADER_CHECKSUM_EN.
module tb_td4_prog_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       load_req;
    logic       core_reset_n;
    logic       loading;
    logic [3:0] wr_ptr;
    logic       done;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prog    [16];
    logic [7:0] exp_mem [16];

    td4_prog_loader_if bus_if ();

    td4_prog_loader dut (
        .clock        (clock),
        .reset        (reset),
        .load_req     (load_req),
        .bus          (bus_if),
        .core_reset_n (core_reset_n),
        .loading      (loading),
        .wr_ptr       (wr_ptr),
        .done         (done),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
        check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
        check({tag, "_loading"}, 32'(loading), 32'd0);
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            bus_if.addr = 4'(a);
            #1;
            check(tag, 32'(bus_if.data), 32'(exp_mem[a]));
        end
    endtask

    // Streams n bytes of prog; vpat gives in_valid per cycle, load_req is raised while acc == req_at.
    task automatic do_load(input int n, input logic [3:0] vpat, input int req_at);
        int acc;
        int cyc;
        logic v;
        logic last;
        load_req = 1'b1;
        @(posedge clock); #1;
        check("enter_loading", 32'(loading), 32'd1);
        check("enter_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("enter_core_reset_n", 32'(core_reset_n), 32'd0);
        check("enter_wr_ptr", 32'(wr_ptr), 32'd0);
        check("enter_error", 32'(error), 32'd0);
        load_req = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 200) begin
            v = vpat[cyc % 4];
            bus_if.in_valid = v;
            bus_if.in_data  = v ? prog[acc] : 8'h5A;
            load_req        = (acc == req_at);
            bus_if.addr     = 4'(acc);
            #1;
            check("wr_ptr", 32'(wr_ptr), 32'(acc));
            check("data_before_write", 32'(bus_if.data), 32'(exp_mem[acc]));
            @(posedge clock); #1;
            if (v) begin
                exp_mem[acc] = prog[acc];
                acc++;
            end
            cyc++;
            last = (acc == 16) && v && !CK;
            check("done", 32'(done), 32'(last));
            check("core_reset_n", 32'(core_reset_n), 32'(last));
            check("loading", 32'(loading), 32'(!last));
        end
        bus_if.in_valid = 1'b0;
        load_req        = 1'b0;
        check("load_budget", 32'(acc), 32'(n));
    endtask

    // Sends the correct checksum when that feature is built, then verifies the core runs.
    task automatic finish_load();
        logic [7:0] s;
        if (CK) begin
            s = 8'h00;
            for (int i = 0; i < 16; i++) s = s + prog[i];
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 8'h00 - s;
            @(posedge clock); #1;
            bus_if.in_valid = 1'b0;
            check("ck_done", 32'(done), 32'd1);
            check("ck_core_reset_n", 32'(core_reset_n), 32'd1);
        end else begin
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("run_core_reset_n", 32'(core_reset_n), 32'd1);
        check("run_in_ready", 32'(bus_if.in_ready), 32'd0);
        check("run_error", 32'(error), 32'd0);
    endtask

    initial begin
        reset           = 1'b0;
        load_req        = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        bus_if.addr     = 4'h0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Reset state and release.
        #12;
        check_reset_outputs("rst");
        reset = 1'b1;
        @(posedge clock); #1;
        check("release_core_reset_n", 32'(core_reset_n), 32'd1);
        check_reset_outputs_after_release: begin
            check("release_done", 32'(done), 32'd0);
            check("release_error", 32'(error), 32'd0);
        end
        check_mem("mem_after_reset");

        // in_valid in RUN is ignored.
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'hAA;
        repeat (3) @(posedge clock);
        #1;
        bus_if.in_valid = 1'b0;
        check("run_ignore_wr_ptr", 32'(wr_ptr), 32'd0);
        check("run_ignore_in_ready", 32'(bus_if.in_ready), 32'd0);
        check_mem("run_ignore_mem");

        // Full load with in_valid held high.
        prog = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                 8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        do_load(16, 4'b1111, -1);
        finish_load();
        bus_if.addr = 4'd4; #1;
        check("addr4", 32'(bus_if.data), 32'h0000_00E3);
        bus_if.addr = 4'd15; #1;
        check("addr15", 32'(bus_if.data), 32'h0000_00FF);
        check_mem("mem_full_load");

        // Reset in the middle of a load discards everything.
        for (int i = 0; i < 16; i++) prog[i] = 8'h40 + 8'(i);
        @(posedge clock); #1;
        do_load(5, 4'b1111, -1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midload_rst");
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        check_mem("mem_after_abort");
        #2;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_release_core_reset_n", 32'(core_reset_n), 32'd1);

        // Same program with in_valid gaps 1,0,0,1.
        prog = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
                 8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};
        do_load(16, 4'b1001, -1);
        finish_load();
        check_mem("mem_gapped_load");

        // load_req during LOAD after 3 bytes has no effect.
        for (int i = 0; i < 16; i++) prog[i] = 8'h5C ^ 8'(i * 17);
        do_load(16, 4'b1111, 3);
        finish_load();
        bus_if.addr = 4'd3; #1;
        check("req_ignored_addr3", 32'(bus_if.data), 32'h0000_006F);
        check_mem("mem_req_ignored");

`ifdef LOADER_CHECKSUM_EN
        // Checksum pass then fail.
        for (int i = 0; i < 16; i++) prog[i] = 8'h01;
        do_load(16, 4'b1111, -1);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'hF0;
        @(posedge clock); #1;
        bus_if.in_valid = 1'b0;
        check("ck_pass_done", 32'(done), 32'd1);
        check("ck_pass_error", 32'(error), 32'd0);
        check("ck_pass_core", 32'(core_reset_n), 32'd1);
        do_load(16, 4'b1111, -1);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'hF1;
        @(posedge clock); #1;
        bus_if.in_valid = 1'b0;
        check("ck_fail_done", 32'(done), 32'd0);
        check("ck_fail_error", 32'(error), 32'd1);
        check("ck_fail_core", 32'(core_reset_n), 32'd0);
        check("ck_fail_loading", 32'(loading), 32'd0);
        check("ck_fail_in_ready", 32'(bus_if.in_ready), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        check("halt_error", 32'(error), 32'd1);
        check("halt_core", 32'(core_reset_n), 32'd0);
        check_mem("halt_mem_kept");
        do_load(16, 4'b1111, -1);
        finish_load();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
